// File: rtl/drum_pkg.sv
// Shared types and constants for the drum hit detector and its per-pad relatives.
// Consumers import drum_pkg::* to get the state enum, widths and velocity scaling.
package drum_pkg;

    localparam int SAMPLE_W  = 12;
    localparam int VEL_W     = 7;
    localparam int VEL_SHIFT = 5;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        MASK = 2'd3
    } drum_state_e;

    function automatic logic [SAMPLE_W-1:0] sample_max(
        input logic [SAMPLE_W-1:0] a,
        input logic [SAMPLE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/drum_velocity_map.sv
// Combinational peak-to-velocity mapping: keep the top VEL_W bits of the peak and
// clamp a zero result to 1 so that a detected hit is never silent.
module drum_velocity_map
    import drum_pkg::*;
(
    input  logic [SAMPLE_W-1:0] peak,
    output logic [VEL_W-1:0]    velocity
);

    logic [VEL_W-1:0]     raw;
    logic [VEL_SHIFT-1:0] unused_low_bits;

    assign raw             = peak[VEL_SHIFT +: VEL_W];
    assign unused_low_bits = peak[VEL_SHIFT-1:0];
    assign velocity        = (raw == '0) ? VEL_W'(1) : raw;

endmodule

// File: rtl/drum_hit_detector.sv
// Piezo strike detector: threshold trigger, peak hold over a sample window, valid/ready
// hit emission and a retrigger mask. Optional accepted-hit counter under DRUM_HIT_COUNT_EN.
module drum_hit_detector
    import drum_pkg::*;
#(
    parameter int SCAN_SAMPLES = 16,
    parameter int MASK_SAMPLES = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] thresh,
    output logic                hit_valid,
    output logic [VEL_W-1:0]    hit_velocity,
    input  logic                hit_ready,
    output logic                busy,
`ifdef DRUM_HIT_COUNT_EN
    output logic [CNT_W-1:0]    hit_count,
`endif
    output drum_state_e         dbg_state
);

    // Handshake: a hit transfers on any cycle where hit_valid && hit_ready; hit_valid
    // never drops before that and hit_velocity is frozen while hit_valid is high.

    localparam logic [CNT_W-1:0] SCAN_LOAD = CNT_W'(SCAN_SAMPLES - 1);
    localparam logic [CNT_W-1:0] MASK_LOAD = CNT_W'(MASK_SAMPLES - 1);

    drum_state_e         state;
    logic [SAMPLE_W-1:0] peak;
    logic [CNT_W-1:0]    cnt;

    logic                trigger;
    logic [SAMPLE_W-1:0] scan_peak;
    logic [SAMPLE_W-1:0] final_peak;
    logic [VEL_W-1:0]    mapped_velocity;

    always_comb begin
        trigger    = 1'b0;
        scan_peak  = sample_max(peak, sample);
        final_peak = scan_peak;
        if (sample_valid && (sample >= thresh)) begin
            trigger = 1'b1;
        end
        // A one-sample window finishes on the triggering sample itself.
        if (state == IDLE) begin
            final_peak = sample;
        end
    end

    drum_velocity_map u_velocity_map (
        .peak     (final_peak),
        .velocity (mapped_velocity)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            peak         <= '0;
            cnt          <= '0;
            hit_valid    <= 1'b0;
            hit_velocity <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        peak <= sample;
                        cnt  <= SCAN_LOAD;
                        busy <= 1'b1;
                        if (SCAN_SAMPLES == 1) begin
                            state        <= EMIT;
                            hit_valid    <= 1'b1;
                            hit_velocity <= mapped_velocity;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    // cnt holds the samples still owed to the window, so the last one
                    // arrives while cnt is 1; below-threshold samples count too.
                    if (sample_valid) begin
                        peak <= scan_peak;
                        cnt  <= cnt - 1'b1;
                        if (cnt <= CNT_W'(1)) begin
                            state        <= EMIT;
                            hit_valid    <= 1'b1;
                            hit_velocity <= mapped_velocity;
                        end
                    end
                end
                EMIT: begin
                    // Samples arriving here, including on the accept cycle, are dropped.
                    if (hit_ready) begin
                        state     <= MASK;
                        hit_valid <= 1'b0;
                        cnt       <= MASK_LOAD;
                    end
                end
                MASK: begin
                    if (sample_valid) begin
                        if (cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    hit_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef DRUM_HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count <= '0;
        end else if (hit_valid && hit_ready) begin
            hit_count <= hit_count + 1'b1;
        end
    end
`endif

    assign dbg_state = state;

endmodule
